// File: rtl/pipe_stage_latch.sv
// Inter-stage pipeline latch: carries a WIDTH-bit bundle through STAGES valid-qualified
// registers, with flush-to-bubble, occupancy and saturating stall/flush counters.
module pipe_stage_latch #(
  parameter int WIDTH = 32,
  parameter int STAGES = 1,
  parameter logic [WIDTH-1:0] CTRL_MASK = {WIDTH{1'b0}},
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             clr_counts,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       occupancy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("pipe_stage_latch: STAGES must be within 1..4");
  end

  localparam logic [WIDTH-1:0] KEEP_MASK = ~CTRL_MASK;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  genvar gi;

  logic [STAGES-1:0]            valid_reg;
  logic [STAGES-1:0]            shift_valid;
  logic [STAGES-1:0][WIDTH-1:0] data_reg;
  logic [STAGES-1:0][WIDTH-1:0] shift_data;
  logic [STAGES-1:0][WIDTH-1:0] bubble_data;
  logic [CNT_W-1:0]             stall_count_reg;
  logic [CNT_W-1:0]             flush_count_reg;
  logic [2:0]                   occupancy_next;

  // Entering bubbles are scrubbed so control bits never need gating by valid.
  assign shift_valid[0] = in_valid;
  assign shift_data[0]  = in_valid ? in_data : (in_data & KEEP_MASK);

  for (gi = 1; gi < STAGES; gi++) begin : g_shift
    assign shift_valid[gi] = valid_reg[gi-1];
    assign shift_data[gi]  = data_reg[gi-1];
  end

  for (gi = 0; gi < STAGES; gi++) begin : g_bubble
    assign bubble_data[gi] = data_reg[gi] & KEEP_MASK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= '0;
      data_reg  <= '0;
    end else if (flush) begin
      valid_reg <= '0;
      data_reg  <= bubble_data;
    end else if (!stall) begin
      valid_reg <= shift_valid;
      data_reg  <= shift_data;
    end
  end

  // Clear outranks increment; a flush cycle never counts as a stall.
  always_ff @(posedge clk) begin
    if (reset || clr_counts) begin
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      if (flush && flush_count_reg != CNT_MAX) begin
        flush_count_reg <= flush_count_reg + CNT_ONE;
      end
      if (stall && !flush && stall_count_reg != CNT_MAX) begin
        stall_count_reg <= stall_count_reg + CNT_ONE;
      end
    end
  end

  always_comb begin
    occupancy_next = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy_next = occupancy_next + 3'(valid_reg[k]);
    end
  end

  assign out_valid   = valid_reg[STAGES-1];
  assign out_data    = data_reg[STAGES-1];
  assign occupancy   = occupancy_next;
  assign stall_count = stall_count_reg;
  assign flush_count = flush_count_reg;

endmodule
